svm_feature_sequencer: RTL and testbench

- Upstream stage of the SVM classifier.
- Accepts a serial stream of signed feature words, one per beat: F_WIDTH valence features, then F_WIDTH arousal features, per entry.
- Assembles each group into a packed vector and drives the SVM `in_features`/`fin_valid`/`fin_ready` port: valence vector first, then arousal vector.
- Assembly and output stages are separate, so entry N+1 can fill while entry N is being consumed.

---
 rtl/svm_feature_sequencer_if.sv | 43 ++++
 rtl/svm_feature_sequencer.sv | 136 +++++++++++++
 tb/tb_svm_feature_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/svm_feature_sequencer_if.sv
// -----------------------------------------------------------------------------
// svm_feature_sequencer_if
//
// Purpose:
//   Groups the two handshakes of the SVM feature sequencer into one bundle.
//   - The serial feature-word stream comes in (feat_*).
//   - The packed modality vector goes out to the SVM (in_features / fin_*).
//
// Signals:
//   feat_in       signed feature word, one per beat
//   feat_valid    feat_in valid
//   feat_ready    sequencer accepts feat_in this cycle
//   in_features   packed vector; feature j at [j*NBITS +: NBITS]
//   fin_valid     in_features valid
//   fin_ready     SVM accepts in_features
//   fin_modality  0 = valence vector presented, 1 = arousal vector presented
//
// Modports:
//   master  the sequencer side (drives the vector toward the SVM)
//   slave   the environment side (feeds words, consumes vectors)
// -----------------------------------------------------------------------------
interface svm_feature_sequencer_if #(
    parameter int NBITS   = 16,
    parameter int F_WIDTH = 20
);
    logic signed [NBITS-1:0]         feat_in;
    logic                            feat_valid;
    logic                            feat_ready;
    logic        [NBITS*F_WIDTH-1:0] in_features;
    logic                            fin_valid;
    logic                            fin_ready;
    logic                            fin_modality;

    modport master (
        input  feat_in, feat_valid, fin_ready,
        output feat_ready, in_features, fin_valid, fin_modality
    );

    modport slave (
        output feat_in, feat_valid, fin_ready,
        input  feat_ready, in_features, fin_valid, fin_modality
    );
endinterface

// File: rtl/svm_feature_sequencer.sv
// -----------------------------------------------------------------------------
// svm_feature_sequencer
//
// Purpose:
//   Upstream stage of the SVM classifier.
//   - Collects a serial stream of signed feature words: F_WIDTH valence words,
//     then F_WIDTH arousal words per entry.
//   - Presents them to the SVM as two packed vectors, valence first, then
//     arousal.
//   - Assembly and output are separate stages, so entry N+1 fills while
//     entry N is being consumed.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   seq          svm_feature_sequencer_if.master (feature stream in, vector out)
//   entry_count  16-bit count of completed entries (SVM_SEQ_ENTRY_CNT_EN only)
//
// Configuration:
//   SVM_SEQ_ENTRY_CNT_EN  when defined, adds the entry_count port and counter.
//                         The counter wraps 0xFFFF -> 0x0000.
// -----------------------------------------------------------------------------
module svm_feature_sequencer #(
    parameter int NBITS       = 16,
    parameter int F_WIDTH     = 20,
    parameter int LOG_F_WIDTH = $clog2(F_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    svm_feature_sequencer_if.master        seq
`ifdef SVM_SEQ_ENTRY_CNT_EN
    ,
    output logic [15:0]                    entry_count
`endif
);
    localparam int VW = NBITS * F_WIDTH;
    localparam logic [LOG_F_WIDTH-1:0] IDX_LAST = LOG_F_WIDTH'(F_WIDTH - 1);

    typedef enum logic [1:0] {FILL_V, FILL_A, ASM_FULL}  asm_state_t;
    typedef enum logic [1:0] {OUT_EMPTY, SEND_V, SEND_A} out_state_t;

    asm_state_t asm_state, asm_next;
    out_state_t out_state, out_next;

    logic [LOG_F_WIDTH-1:0] idx_p0;
    logic [VW-1:0]          val_hold_p0;
    logic [VW-1:0]          aro_hold_p0;
    logic [VW-1:0]          feat_out_p1;
    logic [VW-1:0]          aro_out_p1;

    logic beat_acc;
    logic transfer;
    logic out_hs;

    // Ready is gated by rst so upstream never sees a beat accepted during reset.
    assign seq.feat_ready   = ~rst & (asm_state != ASM_FULL);
    assign beat_acc         = seq.feat_valid & seq.feat_ready;
    assign transfer         = (asm_state == ASM_FULL) & (out_state == OUT_EMPTY);
    assign seq.fin_valid    = (out_state != OUT_EMPTY);
    assign seq.fin_modality = (out_state == SEND_A);
    assign seq.in_features  = feat_out_p1;
    assign out_hs           = seq.fin_valid & seq.fin_ready;

    always_comb begin
        asm_next = asm_state;
        out_next = out_state;

        case (asm_state)
            FILL_V:   if (beat_acc && idx_p0 == IDX_LAST) asm_next = FILL_A;
            FILL_A:   if (beat_acc && idx_p0 == IDX_LAST) asm_next = ASM_FULL;
            ASM_FULL: if (transfer) asm_next = FILL_V;
            default:  asm_next = FILL_V;
        endcase

        case (out_state)
            OUT_EMPTY: if (transfer) out_next = SEND_V;
            SEND_V:    if (out_hs) out_next = SEND_A;
            SEND_A:    if (out_hs) out_next = OUT_EMPTY;
            default:   out_next = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_state <= FILL_V;
            out_state <= OUT_EMPTY;
            idx_p0    <= '0;
        end else begin
            asm_state <= asm_next;
            out_state <= out_next;
            if (beat_acc)
                idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + LOG_F_WIDTH'(1);
        end
    end

    // ---- stage p0: assembly holding registers (data only, no reset) ----
    always_ff @(posedge clk) begin
        if (beat_acc) begin
            if (asm_state == FILL_V)
                val_hold_p0[idx_p0*NBITS +: NBITS] <= seq.feat_in;
            else
                aro_hold_p0[idx_p0*NBITS +: NBITS] <= seq.feat_in;
        end
    end

    // ---- stage p1: output registers ----
    // The valence vector goes straight to the presented register.
    // The arousal vector is parked in aro_out_p1, because assembly may
    // overwrite aro_hold_p0 before the valence handshake completes.
    always_ff @(posedge clk) begin
        if (transfer)
            aro_out_p1 <= aro_hold_p0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            feat_out_p1 <= '0;
        else if (transfer)
            feat_out_p1 <= val_hold_p0;
        else if (out_state == SEND_V && out_hs)
            feat_out_p1 <= aro_out_p1;
    end

`ifdef SVM_SEQ_ENTRY_CNT_EN
    logic [15:0] entry_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            entry_count_q <= 16'd0;
        else if (out_state == SEND_A && out_hs)
            entry_count_q <= entry_count_q + 16'd1;
    end

    assign entry_count = entry_count_q;
`endif
endmodule

// File: tb/tb_svm_feature_sequencer.sv
module tb_svm_feature_sequencer;
    localparam int NB  = 8;
    localparam int FW  = 4;
    localparam int LFW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    svm_feature_sequencer_if #(.NBITS(NB), .F_WIDTH(FW)) bus ();
`ifdef SVM_SEQ_ENTRY_CNT_EN
    logic [15:0] entry_count;
`endif

    svm_feature_sequencer #(.NBITS(NB), .F_WIDTH(FW), .LOG_F_WIDTH(LFW)) dut (
        .clk (clk),
        .rst (rst),
        .seq (bus)
`ifdef SVM_SEQ_ENTRY_CNT_EN
        ,
        .entry_count (entry_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the accepted words in order, grouped into vectors.
    logic [7:0]  words[$];
    logic [31:0] exp_q[$];
    logic [31:0] seen[$];
    int          out_idx;
    int          entries_done;

    // Values sampled on the falling edge.
    logic        s_fr, s_fv, s_fm, s_acc;
    logic [31:0] s_feat;
    logic        hold_pending;
    logic [31:0] held_feat;
    logic        held_mod;

    logic [7:0]  t1 [8];
    logic [7:0]  cur;
    int          wi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        words.delete();
        exp_q.delete();
        out_idx      = 0;
        hold_pending = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] w);
        words.push_back(w);
        if (words.size() == FW) begin
            exp_q.push_back({words[3], words[2], words[1], words[0]});
            words.delete();
        end
    endtask

    // One clock: sample at the falling edge, update the model, advance to just after the rising edge.
    task automatic step();
        @(negedge clk);
        s_fr   = bus.feat_ready;
        s_fv   = bus.fin_valid;
        s_fm   = bus.fin_modality;
        s_feat = bus.in_features;
        s_acc  = bus.feat_valid && s_fr;
        if (hold_pending) begin
            chk("hold_valid", 32'(s_fv), 32'd1);
            chk("hold_data", s_feat, held_feat);
            chk("hold_mod", 32'(s_fm), 32'(held_mod));
        end
        if (s_acc) push_word(bus.feat_in);
        if (s_fv && bus.fin_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_vector", s_feat, 32'hxxxxxxxx);
            end else begin
                chk("vector", s_feat, exp_q.pop_front());
                chk("modality", 32'(s_fm), 32'(out_idx % 2));
                out_idx++;
                seen.push_back(s_feat);
                if (s_fm) entries_done++;
            end
        end
        hold_pending = s_fv && !bus.fin_ready;
        held_feat    = s_feat;
        held_mod     = s_fm;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        bus.feat_in    = w;
        bus.feat_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            if (s_acc) ok = 1'b1;
        end
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        bus.feat_valid = 1'b0;
        bus.fin_ready  = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (exp_q.size() == 0 && !s_fv) done = 1'b1;
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.feat_in    = '0;
        bus.feat_valid = 1'b0;
        bus.fin_ready  = 1'b0;
        model_reset();
        entries_done   = 0;
        hold_pending   = 1'b0;

        // Reset state
        step();
        chk("rst_feat_ready", 32'(s_fr), 32'd0);
        chk("rst_fin_valid", 32'(s_fv), 32'd0);
        chk("rst_fin_modality", 32'(s_fm), 32'd0);
        chk("rst_in_features", s_feat, 32'd0);
`ifdef SVM_SEQ_ENTRY_CNT_EN
        chk("rst_entry_count", 32'(entry_count), 32'd0);
`endif
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(s_fr), 32'd1);

        // 1. Single entry
        t1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFE, 8'hFD, 8'hFC};
        bus.fin_ready = 1'b1;
        for (int k = 0; k < 8; k++) send_word(t1[k]);
        bus.feat_valid = 1'b0;
        step();
        chk("t1_lat_full", 32'(s_fv), 32'd0);
        chk("t1_lat_ready", 32'(s_fr), 32'd0);
        step();
        chk("t1_v_valid", 32'(s_fv), 32'd1);
        chk("t1_v_mod", 32'(s_fm), 32'd0);
        chk("t1_v_data", s_feat, 32'h04030201);
        step();
        chk("t1_a_mod", 32'(s_fm), 32'd1);
        chk("t1_a_data", s_feat, 32'hFCFDFEFF);
        step();
        chk("t1_idle", 32'(s_fv), 32'd0);

        // 2. Output back-pressure
        bus.fin_ready = 1'b0;
        for (int k = 0; k < 8; k++) send_word(8'(8'h10 + k));
        for (int k = 0; k < 8; k++) send_word(8'(8'h20 + k));
        bus.feat_in    = 8'h30;
        bus.feat_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t2_bp_ready", 32'(s_fr), 32'd0);
        end
        bus.feat_valid = 1'b0;
        bus.fin_ready  = 1'b1;
        step();
        chk("t2_e0_v", s_feat, 32'h13121110);
        step();
        chk("t2_e0_a", s_feat, 32'h17161514);
        step();
        chk("t2_gap_valid", 32'(s_fv), 32'd0);
        chk("t2_gap_ready", 32'(s_fr), 32'd0);
        step();
        chk("t2_e1_valid", 32'(s_fv), 32'd1);
        chk("t2_e1_mod", 32'(s_fm), 32'd0);
        chk("t2_e1_ready", 32'(s_fr), 32'd1);
        chk("t2_e1_v", s_feat, 32'h23222120);
        drain();

        // 3. Input bubbles over 3 entries
        bus.fin_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            bus.feat_in    = 8'(8'h40 + k);
            bus.feat_valid = 1'b0;
            step();
            send_word(8'(8'h40 + k));
        end
        drain();
        chk("t3_empty", 32'(exp_q.size()), 32'd0);

        // 4. Reset mid-fill
        for (int k = 0; k < 5; k++) send_word(8'(8'h50 + k));
        bus.feat_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        step();
        chk("t4_rst_ready", 32'(s_fr), 32'd0);
        chk("t4_rst_valid", 32'(s_fv), 32'd0);
        chk("t4_rst_mod", 32'(s_fm), 32'd0);
        chk("t4_rst_data", s_feat, 32'd0);
        rst = 1'b0;
        seen.delete();
        for (int k = 9; k <= 16; k++) send_word(8'(k));
        drain();
        chk("t4_seen_n", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("t4_v", seen[0], 32'h0C0B0A09);
            chk("t4_a", seen[1], 32'h100F0E0D);
        end

        // 5. Random continuous stream of 159 entries
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        entries_done = 0;
        wi  = 0;
        cur = 8'($urandom);
        for (int cyc = 0; cyc < 20000 && wi < 159 * 8; cyc++) begin
            bus.feat_in    = cur;
            bus.feat_valid = ($urandom_range(0, 3) != 0);
            bus.fin_ready  = ($urandom_range(0, 2) != 0);
            step();
            if (s_acc) begin
                wi++;
                cur = 8'($urandom);
            end
        end
        chk("t5_fed", 32'(wi), 32'd1272);
        drain();
        chk("t5_entries", 32'(entries_done), 32'd159);
        chk("t5_empty", 32'(exp_q.size()), 32'd0);
`ifdef SVM_SEQ_ENTRY_CNT_EN
        chk("t5_entry_count", 32'(entry_count), 32'd159);

        // 6. Counter wrap
        force dut.entry_count_q = 16'hFFFF;
        step();
        release dut.entry_count_q;
        step();
        chk("t6_forced", 32'(entry_count), 32'h0000FFFF);
        for (int k = 0; k < 8; k++) send_word(8'(8'h60 + k));
        drain();
        chk("t6_wrap", 32'(entry_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
